// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between requesting blocks and the round-robin decode arbiter.
// The arbiter drives the registered grant outputs; requesters drive req and done.
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters, one-hot grant held until done, request drop or hold limit.
// Grant is registered one edge after req is sampled; one IDLE cycle always separates two grants.
module rr_decode_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_decode_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [2:0]         ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [7:0]         grant_q;
  logic [2:0]         grant_idx_q;
  logic               grant_valid_q;
  logic               timeout_q;

  logic [2:0]         winner;
  logic               any_req;
  logic               at_limit;
  logic               holder_req;
  logic               rel;

  // Scan from ptr upward with 3-bit wraparound; first set bit wins.
  always_comb begin
    logic [2:0] idx;
    winner  = ptr;
    any_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!any_req && bus.req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign at_limit   = (hold_cnt == CNT_W'(HOLD_MAX - 1));
  assign holder_req = bus.req[grant_idx_q];
  assign rel        = bus.done || !holder_req || at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      hold_cnt      <= '0;
      grant_q       <= 8'h00;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state         <= GRANT;
            grant_idx_q   <= winner;
            grant_q       <= 8'h01 << winner;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state         <= IDLE;
            grant_q       <= 8'h00;
            grant_valid_q <= 1'b0;
            ptr           <= grant_idx_q + 3'd1;
            // Flag only a forced release: a coincident done or request drop is a normal release.
            timeout_q     <= at_limit && !bus.done && holder_req;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: one instance with HOLD_MAX=8, one with HOLD_MAX=4.
module tb_rr_decode_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  rr_decode_arbiter_if b8();
  rr_decode_arbiter_if b4();

  rr_decode_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  rr_decode_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;

  logic [12:0] o8, o4;
  assign o8 = {b8.grant_valid, b8.grant_idx, b8.grant, b8.timeout};
  assign o4 = {b4.grant_valid, b4.grant_idx, b4.grant, b4.timeout};

  // Expected {grant_valid, grant_idx, grant, timeout}; grant is the decode of idx when valid.
  function automatic logic [12:0] ex(input logic v, input logic [2:0] i, input logic t);
    logic [7:0] g;
    g  = v ? (8'h01 << i) : 8'h00;
    ex = {v, i, g, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b8.req = 8'h00; b8.done = 1'b0;
    b4.req = 8'h00; b4.done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o8 !== ex(1'b0, 3'd0, 1'b0)) begin
      failures++; $display("FAIL reset8 got=%h exp=%h", o8, ex(1'b0, 3'd0, 1'b0));
    end
    checks++;
    if (o4 !== ex(1'b0, 3'd0, 1'b0)) begin
      failures++; $display("FAIL reset4 got=%h exp=%h", o4, ex(1'b0, 3'd0, 1'b0));
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    b8.req = 8'h10;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (o8 !== ex(1'b1, 3'd4, 1'b0)) begin
        failures++; $display("FAIL hold8 cycle %0d got=%h exp=%h", i, o8, ex(1'b1, 3'd4, 1'b0));
      end
    end
    step();
    checks++;
    if (o8 !== ex(1'b0, 3'd4, 1'b1)) begin
      failures++; $display("FAIL timeout8 got=%h exp=%h", o8, ex(1'b0, 3'd4, 1'b1));
    end
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd4, 1'b0)) begin
      failures++; $display("FAIL regrant8 got=%h exp=%h", o8, ex(1'b1, 3'd4, 1'b0));
    end
    b8.req = 8'h00;
    step();
    checks++;
    if (o8 !== ex(1'b0, 3'd4, 1'b0)) begin
      failures++; $display("FAIL drop_after_regrant got=%h exp=%h", o8, ex(1'b0, 3'd4, 1'b0));
    end
  endtask

  task automatic test_rotation();
    do_reset();
    b8.req  = 8'hFF;
    b8.done = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      checks++;
      if (o8 !== ex(1'b1, 3'(i % 8), 1'b0)) begin
        failures++; $display("FAIL rotate_grant %0d got=%h exp=%h", i, o8, ex(1'b1, 3'(i % 8), 1'b0));
      end
      step();
      checks++;
      if (o8 !== ex(1'b0, 3'(i % 8), 1'b0)) begin
        failures++; $display("FAIL rotate_idle %0d got=%h exp=%h", i, o8, ex(1'b0, 3'(i % 8), 1'b0));
      end
    end
    b8.req  = 8'h00;
    b8.done = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    b8.req = 8'h40;
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd6, 1'b0)) begin
      failures++; $display("FAIL wrap_setup got=%h exp=%h", o8, ex(1'b1, 3'd6, 1'b0));
    end
    b8.req = 8'h81;
    step();
    checks++;
    if (o8 !== ex(1'b0, 3'd6, 1'b0)) begin
      failures++; $display("FAIL wrap_release6 got=%h exp=%h", o8, ex(1'b0, 3'd6, 1'b0));
    end
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd7, 1'b0)) begin
      failures++; $display("FAIL wrap_win7 got=%h exp=%h", o8, ex(1'b1, 3'd7, 1'b0));
    end
    b8.done = 1'b1;
    step();
    checks++;
    if (o8 !== ex(1'b0, 3'd7, 1'b0)) begin
      failures++; $display("FAIL wrap_release7 got=%h exp=%h", o8, ex(1'b0, 3'd7, 1'b0));
    end
    b8.done = 1'b0;
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd0, 1'b0)) begin
      failures++; $display("FAIL wrap_win0 got=%h exp=%h", o8, ex(1'b1, 3'd0, 1'b0));
    end
    b8.req = 8'h00;
    step();
  endtask

  task automatic test_timeout4();
    do_reset();
    b4.req = 8'h02;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (o4 !== ex(1'b1, 3'd1, 1'b0)) begin
        failures++; $display("FAIL hold4 cycle %0d got=%h exp=%h", i, o4, ex(1'b1, 3'd1, 1'b0));
      end
    end
    step();
    checks++;
    if (o4 !== ex(1'b0, 3'd1, 1'b1)) begin
      failures++; $display("FAIL timeout4 got=%h exp=%h", o4, ex(1'b0, 3'd1, 1'b1));
    end
    // ptr must now be 2, so requester 2 beats requester 1.
    b4.req = 8'h06;
    step();
    checks++;
    if (o4 !== ex(1'b1, 3'd2, 1'b0)) begin
      failures++; $display("FAIL ptr_after_timeout4 got=%h exp=%h", o4, ex(1'b1, 3'd2, 1'b0));
    end
    b4.req = 8'h00;
    step();
  endtask

  task automatic test_done_at_limit();
    do_reset();
    b4.req = 8'h02;
    repeat (4) step();
    checks++;
    if (o4 !== ex(1'b1, 3'd1, 1'b0)) begin
      failures++; $display("FAIL limit_setup got=%h exp=%h", o4, ex(1'b1, 3'd1, 1'b0));
    end
    b4.done = 1'b1;
    step();
    checks++;
    if (o4 !== ex(1'b0, 3'd1, 1'b0)) begin
      failures++; $display("FAIL done_at_limit got=%h exp=%h", o4, ex(1'b0, 3'd1, 1'b0));
    end
    b4.done = 1'b0;
    b4.req  = 8'h00;
    step();
    checks++;
    if (o4 !== ex(1'b0, 3'd1, 1'b0)) begin
      failures++; $display("FAIL idle_after_limit got=%h exp=%h", o4, ex(1'b0, 3'd1, 1'b0));
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    b8.req = 8'h08;
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd3, 1'b0)) begin
      failures++; $display("FAIL drop_grant got=%h exp=%h", o8, ex(1'b1, 3'd3, 1'b0));
    end
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd3, 1'b0)) begin
      failures++; $display("FAIL drop_hold got=%h exp=%h", o8, ex(1'b1, 3'd3, 1'b0));
    end
    // Other requests arriving mid-grant must not steal it; req[3] dropping releases.
    b8.req = 8'h17;
    step();
    checks++;
    if (o8 !== ex(1'b0, 3'd3, 1'b0)) begin
      failures++; $display("FAIL drop_release got=%h exp=%h", o8, ex(1'b0, 3'd3, 1'b0));
    end
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd4, 1'b0)) begin
      failures++; $display("FAIL drop_ptr4 got=%h exp=%h", o8, ex(1'b1, 3'd4, 1'b0));
    end
    b8.req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    b8.req = 8'h20;
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd5, 1'b0)) begin
      failures++; $display("FAIL midrst_grant got=%h exp=%h", o8, ex(1'b1, 3'd5, 1'b0));
    end
    rst    = 1'b1;
    b8.req = 8'hFF;
    step();
    checks++;
    if (o8 !== ex(1'b0, 3'd0, 1'b0)) begin
      failures++; $display("FAIL midrst_clear got=%h exp=%h", o8, ex(1'b0, 3'd0, 1'b0));
    end
    rst = 1'b0;
    step();
    checks++;
    if (o8 !== ex(1'b1, 3'd0, 1'b0)) begin
      failures++; $display("FAIL midrst_win0 got=%h exp=%h", o8, ex(1'b1, 3'd0, 1'b0));
    end
    b8.req = 8'h00;
    step();
  endtask

  initial begin
    rst = 1'b1;
    b8.req = 8'h00; b8.done = 1'b0;
    b4.req = 8'h00; b4.done = 1'b0;
    test_reset();
    test_single_hold();
    test_rotation();
    test_wrap();
    test_timeout4();
    test_done_at_limit();
    test_req_drop();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
